// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between NREQ requesters,
// with registered 1-cycle responses and a lock handshake guarded by a watchdog.
module dmem_arbiter #(
  parameter int NREQ      = 2,
  parameter int MEM_WORDS = 64,
  parameter int LOCK_MAX  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ-1:0]      req_lock,
  input  logic [NREQ*32-1:0]   req_addr,
  input  logic [NREQ*32-1:0]   req_wdata,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      resp_valid,
  output logic [31:0]          resp_rdata,
  output logic                 resp_err,
  output logic                 lock_abort,
  output logic                 mem_we,
  output logic [31:0]          mem_a,
  output logic [31:0]          mem_wd,
  input  logic [31:0]          mem_rd
);

  localparam int PW = (NREQ > 2) ? 2 : 1;
  localparam int CW = $clog2(LOCK_MAX) + 1;

  typedef enum logic {ARB, LOCKED} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [PW-1:0]   owner, owner_nxt;
  logic [CW-1:0]   lock_cnt, lock_cnt_nxt;
  logic [PW-1:0]   win, cand;
  logic            grant, accept, abort_nxt;
  logic [31:0]     w_addr, w_wdata;
  logic            w_we, w_lock, w_err;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(NREQ - 1)) ? '0 : p + 1'b1;
  endfunction

  // Winner: owner only while locked, else first valid scanning upward from rr_ptr.
  always_comb begin
    win   = '0;
    grant = 1'b0;
    cand  = rr_ptr;
    if (state == LOCKED) begin
      win   = owner;
      grant = req_valid[owner];
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!grant && req_valid[cand]) begin
          grant = 1'b1;
          win   = cand;
        end
        cand = nxt(cand);
      end
    end
  end

  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (PW'(i) == win) begin
        w_addr  = req_addr[i*32 +: 32];
        w_wdata = req_wdata[i*32 +: 32];
      end
    end
    w_we   = req_we[win];
    w_lock = req_lock[win];
    w_err  = (w_addr[1:0] != 2'b00) || (w_addr >= 32'(MEM_WORDS * 4));
    accept = grant && rst_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB;
      rr_ptr   <= '0;
      owner    <= '0;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      owner    <= owner_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

  // An owner accept always beats the watchdog, so the timeout is only in the else path.
  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    owner_nxt    = owner;
    lock_cnt_nxt = lock_cnt;
    abort_nxt    = 1'b0;
    case (state)
      ARB: begin
        if (accept) begin
          rr_ptr_nxt = nxt(win);
          if (w_lock && !w_err) begin
            state_nxt    = LOCKED;
            owner_nxt    = win;
            lock_cnt_nxt = '0;
          end
        end
      end
      LOCKED: begin
        if (accept) begin
          lock_cnt_nxt = '0;
          if (!w_lock || w_err) begin
            state_nxt  = ARB;
            rr_ptr_nxt = nxt(owner);
          end
        end else if (lock_cnt == CW'(LOCK_MAX - 1)) begin
          state_nxt    = ARB;
          rr_ptr_nxt   = nxt(owner);
          lock_cnt_nxt = '0;
          abort_nxt    = 1'b1;
        end else begin
          lock_cnt_nxt = lock_cnt + 1'b1;
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win] = 1'b1;
    mem_we = accept && w_we && !w_err;
    mem_a  = grant ? w_addr  : '0;
    mem_wd = grant ? w_wdata : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      lock_abort <= 1'b0;
    end else begin
      resp_valid <= req_ready;
      resp_rdata <= (accept && !w_we && !w_err) ? mem_rd : '0;
      resp_err   <= accept && w_err;
      lock_abort <= abort_nxt;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: 2 requesters, 64-word memory model, LOCK_MAX=16.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid, req_we, req_lock;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_ready, resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err, lock_abort, mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic [31:0] mem [64];

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.NREQ(2), .MEM_WORDS(64), .LOCK_MAX(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .lock_abort(lock_abort),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: preloaded with 0xA0000000+index on reset, combinational read.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 + 32'(i);
    end else if (mem_we && mem_a < 32'd256) begin
      mem[mem_a[7:2]] <= mem_wd;
    end
  end
  assign mem_rd = (mem_a < 32'd256) ? mem[mem_a[7:2]] : 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic v, input logic we, input logic lk,
                         input logic [31:0] a, input logic [31:0] d);
    req_valid[idx]          = v;
    req_we[idx]             = we;
    req_lock[idx]           = lk;
    req_addr[idx*32 +: 32]  = a;
    req_wdata[idx*32 +: 32] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    set_req(0, 1, 0, 0, 32'h0, 32'h0);
    set_req(1, 1, 0, 0, 32'h4, 32'h0);
    #1;
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_resp_valid", resp_valid, 2'b00);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", resp_err, 1'b0);
    chk("rst_abort", lock_abort, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);

    // Round-robin with both requesters loading
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rr_ready", req_ready, (k % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      chk("rr_resp_valid", resp_valid, (k % 2 == 0) ? 32'h1 : 32'h2);
      chk("rr_rdata", resp_rdata, 32'hA000_0000 + ((k % 2 == 0) ? 32'h0 : 32'h1));
    end

    // Store then load to the same address on consecutive cycles
    set_req(1, 0, 0, 0, 32'h0, 32'h0);
    set_req(0, 1, 1, 0, 32'h10, 32'hDEAD_BEEF);
    #1;
    chk("st_ready", req_ready, 2'b01);
    chk("st_mem_we", mem_we, 1'b1);
    chk("st_mem_a", mem_a, 32'h10);
    chk("st_mem_wd", mem_wd, 32'hDEAD_BEEF);
    tick();
    chk("st_resp_valid", resp_valid, 2'b01);
    chk("st_rdata", resp_rdata, 32'h0);
    chk("st_err", resp_err, 1'b0);
    set_req(0, 1, 0, 0, 32'h10, 32'h0);
    #1;
    tick();
    chk("ld_rdata", resp_rdata, 32'hDEAD_BEEF);
    chk("ld_err", resp_err, 1'b0);

    // Misaligned load, out-of-range store, then last legal word
    set_req(0, 1, 0, 0, 32'h13, 32'h0);
    #1;
    chk("mis_mem_we", mem_we, 1'b0);
    tick();
    chk("mis_resp_valid", resp_valid, 2'b01);
    chk("mis_err", resp_err, 1'b1);
    chk("mis_rdata", resp_rdata, 32'h0);
    set_req(0, 1, 1, 0, 32'h100, 32'h1234_5678);
    #1;
    chk("oor_mem_we", mem_we, 1'b0);
    tick();
    chk("oor_err", resp_err, 1'b1);
    chk("oor_rdata", resp_rdata, 32'h0);
    set_req(0, 1, 0, 0, 32'hFC, 32'h0);
    #1;
    tick();
    chk("last_err", resp_err, 1'b0);
    chk("last_rdata", resp_rdata, 32'hA000_003F);

    // Asynchronous reset in the middle of traffic (rr_ptr now points at req1)
    set_req(0, 1, 0, 0, 32'h0, 32'h0);
    set_req(1, 1, 0, 0, 32'h4, 32'h0);
    #1;
    chk("pre_rst_ready", req_ready, 2'b10);
    tick();
    chk("pre_rst_resp_valid", resp_valid, 2'b10);
    rst_n = 1'b0;
    #1;
    chk("async_resp_valid", resp_valid, 2'b00);
    chk("async_ready", req_ready, 2'b00);
    chk("async_rdata", resp_rdata, 32'h0);
    chk("async_mem_we", mem_we, 1'b0);
    tick();
    chk("held_resp_valid", resp_valid, 2'b00);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", req_ready, 2'b01);
    tick();
    chk("post_rst_resp_valid", resp_valid, 2'b01);
    chk("post_rst_rdata", resp_rdata, 32'hA000_0000);

    // Atomic sequence: req1 load+lock, req0 waits throughout
    set_req(1, 1, 0, 1, 32'h20, 32'h0);
    #1;
    chk("lk_ready", req_ready, 2'b10);
    tick();
    chk("lk_resp_valid", resp_valid, 2'b10);
    chk("lk_rdata", resp_rdata, 32'hA000_0008);
    set_req(1, 0, 0, 0, 32'h0, 32'h0);
    #1;
    chk("lk_block0", req_ready, 2'b00);
    tick();
    chk("lk_block1", req_ready, 2'b00);
    chk("lk_no_resp", resp_valid, 2'b00);
    set_req(1, 1, 1, 0, 32'h20, 32'hCAFE_0001);
    #1;
    chk("lk_st_ready", req_ready, 2'b10);
    chk("lk_st_mem_we", mem_we, 1'b1);
    tick();
    chk("lk_st_resp_valid", resp_valid, 2'b10);
    chk("unlk_ready", req_ready, 2'b01);
    chk("unlk_mem", mem[8], 32'hCAFE_0001);
    set_req(1, 0, 0, 0, 32'h0, 32'h0);
    set_req(0, 1, 0, 0, 32'h20, 32'h0);
    #1;
    tick();
    chk("unlk_rdata", resp_rdata, 32'hCAFE_0001);

    // Lock watchdog: owner req0 idles, req1 waits
    set_req(0, 1, 0, 1, 32'h0, 32'h0);
    #1;
    chk("to_lk_ready", req_ready, 2'b01);
    tick();
    chk("to_lk_resp_valid", resp_valid, 2'b01);
    set_req(0, 0, 0, 0, 32'h0, 32'h0);
    set_req(1, 1, 0, 0, 32'h4, 32'h0);
    #1;
    for (int k = 0; k < 16; k++) begin
      chk("to_wait_ready", req_ready, 2'b00);
      chk("to_wait_abort", lock_abort, 1'b0);
      tick();
    end
    chk("to_abort", lock_abort, 1'b1);
    chk("to_req1_ready", req_ready, 2'b10);
    tick();
    chk("to_abort_clear", lock_abort, 1'b0);
    chk("to_req1_resp", resp_valid, 2'b10);
    chk("to_req1_rdata", resp_rdata, 32'hA000_0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
